// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and width helpers for the fifo write-port arbiter.
//   - arb_state_t : arbiter FSM states (IDLE = round-robin, LOCK = burst owner held)
//   - idx_width() : width of a producer index, never below 1 bit
//   - cnt_width() : width of the burst beat counter, able to hold MAX_BURST
package fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Returns the first requester found when
//   scanning from i_start upward, wrapping past N-1 back to 0.
//   Ports:
//     i_req   [N-1:0]  request vector
//     i_start [IW-1:0] scan start index (must be < N)
//     o_found          at least one request present
//     o_idx   [IW-1:0] selected index (0 when o_found=0)
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_start,
   output logic          o_found,
   output logic [IW-1:0] o_idx
);

   logic [2*N-1:0] w_dbl;
   logic [2*N-1:0] w_mask;
   logic [2*N-1:0] w_cand;

   // The request vector is laid out twice; masking off the bits below i_start
   // in the lower copy leaves the upper copy to supply the wrapped-around part,
   // so a plain lowest-bit priority encoder yields round-robin order.
   assign w_dbl = {i_req, i_req};

   generate
      for (genvar gi = 0; gi < 2*N; gi++) begin : g_mask
         assign w_mask[gi] = (gi >= int'(i_start));
      end
   endgenerate

   assign w_cand = w_dbl & w_mask;

   // Scan from the top down so the lowest candidate bit wins.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int j = 2*N-1; j >= 0; j--) begin
         if (w_cand[j]) begin
            o_found = 1'b1;
            o_idx   = IW'((j >= N) ? (j - N) : j);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares one fifo write port between N_REQ producers. Round-robin in IDLE;
//   a beat without 'last' locks the port to that producer for up to MAX_BURST
//   beats. Grants are combinational (zero latency) and never issued while the
//   fifo is full; a full fifo freezes all arbitration state.
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     i_req   [N_REQ-1:0]             per-producer beat valid
//     i_last  [N_REQ-1:0]             per-producer end-of-burst, qualified by i_req
//     i_data  [N_REQ*DW-1:0]          producer i data on [i*DW +: DW]
//     o_gnt   [N_REQ-1:0]             one-hot beat accept
//     i_fifo_full                     fifo full flag
//     o_fifo_wen                      fifo write enable (= |o_gnt)
//     o_fifo_wdata [DW-1:0]           granted producer data, 0 when idle
//     o_owner [IDXW-1:0]              current / most recently granted producer
//     o_busy                          high while a burst lock is held
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int N_REQ     = 4,
   parameter  int DW        = 8,
   parameter  int MAX_BURST = 4,
   localparam int IDXW      = idx_width(N_REQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    i_req,
   input  logic [N_REQ-1:0]    i_last,
   input  logic [N_REQ*DW-1:0] i_data,
   output logic [N_REQ-1:0]    o_gnt,
   input  logic                i_fifo_full,
   output logic                o_fifo_wen,
   output logic [DW-1:0]       o_fifo_wdata,
   output logic [IDXW-1:0]     o_owner,
   output logic                o_busy
);

   localparam int CW = cnt_width(MAX_BURST);

   arb_state_t      r_state,    w_state_next;
   logic [IDXW-1:0] r_rr_ptr,   w_rr_ptr_next;
   logic [IDXW-1:0] r_owner,    w_owner_next;
   logic [CW-1:0]   r_beat_cnt, w_beat_cnt_next;

   logic            w_pick_found;
   logic [IDXW-1:0] w_pick_idx;
   logic [IDXW-1:0] w_sel_idx;
   logic            w_sel_req;
   logic            w_sel_last;
   logic            w_accept;
   logic            w_burst_end;
   logic [IDXW-1:0] w_ptr_after;
   logic [DW-1:0]   w_data_arr [N_REQ];

   rr_pick #(
      .N  (N_REQ),
      .IW (IDXW)
   ) u_rr_pick (
      .i_req   (i_req),
      .i_start (r_rr_ptr),
      .o_found (w_pick_found),
      .o_idx   (w_pick_idx)
   );

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_chan
         assign w_data_arr[gi] = i_data[gi*DW +: DW];
         assign o_gnt[gi]      = w_accept && (int'(w_sel_idx) == gi);
      end
   endgenerate

   // Candidate selection: round-robin winner in IDLE, only the owner in LOCK.
   // rst_n gates the accept so nothing is granted while reset is held.
   always_comb begin
      w_sel_idx = r_owner;
      w_sel_req = 1'b0;
      if (r_state == IDLE) begin
         w_sel_idx = w_pick_idx;
         w_sel_req = w_pick_found;
      end else begin
         w_sel_req = i_req[r_owner];
      end
      w_sel_last  = i_last[w_sel_idx];
      w_accept    = w_sel_req && !i_fifo_full && rst_n;
      w_burst_end = (int'(r_beat_cnt) + 1 == MAX_BURST);
      w_ptr_after = (int'(w_sel_idx) == N_REQ - 1) ? '0 : w_sel_idx + IDXW'(1);
   end

   assign o_fifo_wen   = |o_gnt;
   assign o_fifo_wdata = w_accept ? w_data_arr[w_sel_idx] : '0;
   assign o_owner      = r_owner;
   assign o_busy       = (r_state == LOCK);

   // Next-state logic. Without an accepted beat (no request, or fifo full)
   // every register holds, which is what freezes the arbiter on full.
   always_comb begin
      w_state_next    = r_state;
      w_rr_ptr_next   = r_rr_ptr;
      w_owner_next    = r_owner;
      w_beat_cnt_next = r_beat_cnt;
      if (w_accept) begin
         w_owner_next = w_sel_idx;
         case (r_state)
            IDLE: begin
               // A single-beat budget makes every beat behave as a last beat.
               if (w_sel_last || (MAX_BURST == 1)) begin
                  w_rr_ptr_next = w_ptr_after;
               end else begin
                  w_state_next    = LOCK;
                  w_beat_cnt_next = CW'(1);
               end
            end
            LOCK: begin
               if (w_sel_last || w_burst_end) begin
                  w_state_next    = IDLE;
                  w_rr_ptr_next   = w_ptr_after;
                  w_beat_cnt_next = '0;
               end else begin
                  w_beat_cnt_next = r_beat_cnt + CW'(1);
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_rr_ptr   <= '0;
         r_owner    <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_rr_ptr   <= w_rr_ptr_next;
         r_owner    <= w_owner_next;
         r_beat_cnt <= w_beat_cnt_next;
      end
   end

`ifdef FORMAL
   a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(o_gnt));
   a_no_wr_full:  assert property (@(posedge clk) disable iff (!rst_n) !(o_fifo_wen && i_fifo_full));
   a_cnt_bound:   assert property (@(posedge clk) disable iff (!rst_n) int'(r_beat_cnt) <= MAX_BURST);
   a_lock_owner:  assert property (@(posedge clk) disable iff (!rst_n)
                                   o_busy |-> ((o_gnt & ~(N_REQ'(1) << r_owner)) == '0));
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed scenarios followed by randomized producer traffic, all checked
//   against a reference model of the arbitration rules (round-robin scan,
//   burst lock with forced release, freeze on full, async reset).
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   last;
   logic [DW-1:0]  dat [N];
   logic [N*DW-1:0] data_bus;
   logic           full;
   logic [N-1:0]   gnt;
   logic           wen;
   logic [DW-1:0]  wdata;
   logic [1:0]     owner;
   logic           busy;

   int n_cmp;
   int n_err;

   // reference model state
   bit m_locked;
   int m_ptr;
   int m_owner;
   int m_cnt;
   int g_last;

   assign data_bus = {dat[3], dat[2], dat[1], dat[0]};

   fifo_wr_arbiter #(
      .N_REQ     (N),
      .DW        (DW),
      .MAX_BURST (MB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_req        (req),
      .i_last       (last),
      .i_data       (data_bus),
      .o_gnt        (gnt),
      .i_fifo_full  (full),
      .o_fifo_wen   (wen),
      .o_fifo_wdata (wdata),
      .o_owner      (owner),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_locked = 1'b0;
      m_ptr    = 0;
      m_owner  = 0;
      m_cnt    = 0;
   endfunction

   // Index the arbitration rules say is granted this cycle, or -1.
   function automatic int model_grant();
      int e;
      e = -1;
      if (rst_n && !full) begin
         if (m_locked) begin
            if (req[m_owner]) e = m_owner;
         end else begin
            for (int k = N - 1; k >= 0; k--)
               if (req[(m_ptr + k) % N]) e = (m_ptr + k) % N;
         end
      end
      return e;
   endfunction

   function automatic void model_accept(input int e);
      m_owner = e;
      if (!m_locked) begin
         if (last[e] || MB == 1) m_ptr = (e + 1) % N;
         else begin
            m_locked = 1'b1;
            m_cnt    = 1;
         end
      end else begin
         m_cnt = m_cnt + 1;
         if (last[e] || m_cnt == MB) begin
            m_locked = 1'b0;
            m_cnt    = 0;
            m_ptr    = (e + 1) % N;
         end
      end
   endfunction

   // One clock: inputs were set just after a falling edge.
   task automatic cycle(input string tag);
      int e;
      #1;
      e = model_grant();
      chk({tag, ".gnt"},   32'(gnt),   (e >= 0) ? (32'd1 << e) : 32'd0);
      chk({tag, ".wen"},   32'(wen),   32'(e >= 0));
      chk({tag, ".wdata"}, 32'(wdata), (e >= 0) ? 32'(dat[e]) : 32'd0);
      @(posedge clk);
      if (!rst_n) model_reset();
      else if (e >= 0) model_accept(e);
      #1;
      chk({tag, ".owner"}, 32'(owner), 32'(m_owner));
      chk({tag, ".busy"},  32'(busy),  32'(m_locked));
      g_last = e;
      $display("[%0t] %s req=%b last=%b full=%0d gnt=%b wdata=%02h owner=%0d busy=%0d",
               $time, tag, req, last, full, gnt, wdata, owner, busy);
      @(negedge clk);
   endtask

   task automatic new_beat(input int i);
      req[i]  = ($urandom % 4) != 0;
      last[i] = $urandom % 2;
      dat[i]  = DW'($urandom);
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      g_last = -1;
      rst_n  = 1'b0;
      full   = 1'b0;
      req    = '0;
      last   = '0;
      for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
      model_reset();
      @(negedge clk);

      // 1. reset with all requesting
      req  = 4'b1111;
      last = 4'b1111;
      cycle("rst");
      cycle("rst");
      rst_n = 1'b1;

      // 2. round-robin single beats
      for (int k = 0; k < 5; k++) begin
         cycle("rr");
         if (g_last >= 0) dat[g_last] = DW'($urandom);
      end

      // 3. pointer back to 0 via P3, then 3-beat burst from P0 while P1 waits
      req  = 4'b1000;
      last = 4'b1000;
      cycle("p3");
      req  = 4'b0011;
      last = 4'b0010;
      cycle("burst3");
      dat[0] = DW'($urandom);
      cycle("burst3");
      dat[0] = DW'($urandom);
      last[0] = 1'b1;
      cycle("burst3");
      req[0] = 1'b0;
      cycle("after3");

      // 4. stall mid-burst from P0
      req  = 4'b0001;
      last = 4'b0000;
      cycle("stall");
      full = 1'b1;
      cycle("stall");
      cycle("stall");
      full = 1'b0;
      for (int k = 0; k < 3; k++) begin
         dat[0] = DW'($urandom);
         cycle("resume");
      end

      // 5. P2 streams without last, forced release hands over to P3
      req  = 4'b1100;
      last = 4'b1000;
      for (int k = 0; k < 5; k++) begin
         cycle("force");
         if (g_last >= 0) dat[g_last] = DW'($urandom);
      end
      req = 4'b0000;
      cycle("idle");

      // 6. reset pulsed during the second beat of a P1 burst
      req  = 4'b0010;
      last = 4'b0000;
      cycle("abort");
      rst_n = 1'b0;
      cycle("abort");
      rst_n = 1'b1;
      req  = 4'b0011;
      last = 4'b0011;
      cycle("post_rst");

      // randomized traffic; each producer holds its beat until granted
      for (int i = 0; i < N; i++) new_beat(i);
      for (int k = 0; k < 400; k++) begin
         full = ($urandom % 4) == 0;
         cycle("rand");
         for (int i = 0; i < N; i++)
            if (!req[i] || g_last == i) new_beat(i);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
